dmem_stage: RTL and testbench

Pipeline memory stage of the 16-bit pipelined core. It sits between the EX/MEM pipeline register and the writeback stage. Loads and stores go to the multi-cycle data memory/cache, and the block stalls the upstream pipeline until each access completes. It then presents registered MEM/WB results together with the commit-level observation signals (memRead, memWrite, aluResult, writeData, readData, halt, D-cache request/hit) that the trace bench samples.

---
 rtl/dmem_stage.sv | 118 +++++++++++
 tb/tb_dmem_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage.sv
// Pipeline memory stage: issues one data-memory access per load/store, stalls the
// upstream pipeline until it completes, and registers MEM/WB plus commit observation.
// state  | meaning
// IDLE   | accepting ops; drives the request for a memory op until accepted
// WAIT   | request accepted, waiting for mem_done
// HALTED | HALT committed; inputs discarded until rst
module dmem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              memToReg_in,
  input  logic              regWrite_in,
  input  logic [REG_W-1:0]  wrReg_in,
  input  logic              halt_in,
  input  logic [DATA_W-1:0] aluResult_in,
  input  logic [DATA_W-1:0] writeData_in,
  output logic              stall,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_hit,
  input  logic              mem_err,
  output logic              valid_out,
  output logic              regWrite_out,
  output logic [REG_W-1:0]  wrReg_out,
  output logic [DATA_W-1:0] wbData_out,
  output logic              halt_out,
  output logic              memRead,
  output logic              memWrite,
  output logic              halt,
  output logic [DATA_W-1:0] aluResult,
  output logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              dcache_req,
  output logic              dcache_hit,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
  state_t state;

  logic              mem_op, is_load, is_store, req, from_mem, commit;
  logic [DATA_W-1:0] wb_data;

  always_comb begin
    mem_op    = memRead_in | memWrite_in;
    is_store  = memWrite_in;
    // a read+write conflict executes as a store
    is_load   = memRead_in & ~memWrite_in;
    req       = (state == IDLE) & valid_in & mem_op & ~rst;
    mem_rd    = req & is_load;
    mem_wr    = req & is_store;
    mem_addr  = req ? aluResult_in : '0;
    mem_wdata = req ? writeData_in : '0;
    from_mem  = (state == WAIT);
    commit    = ((state == IDLE) & valid_in & ~mem_op) | (from_mem & mem_done);
    wb_data   = (from_mem & memToReg_in) ? mem_rdata : aluResult_in;
    stall     = 1'b0;
    case (state)
      IDLE:    stall = valid_in & mem_op;
      WAIT:    stall = ~mem_done;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      err          <= 1'b0;
      valid_out    <= 1'b0;
      regWrite_out <= 1'b0;
      wrReg_out    <= '0;
      wbData_out   <= '0;
      halt_out     <= 1'b0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      halt         <= 1'b0;
      aluResult    <= '0;
      writeData    <= '0;
      readData     <= '0;
      dcache_req   <= 1'b0;
      dcache_hit   <= 1'b0;
    end else begin
      if (mem_err || (state == IDLE && valid_in && memRead_in && memWrite_in))
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (commit && halt_in)    state <= HALTED;
          else if (req && !mem_stall) state <= WAIT;
        end
        WAIT:    if (mem_done) state <= halt_in ? HALTED : IDLE;
        default: state <= HALTED;
      endcase
      // observation registers read as zero whenever nothing commits
      valid_out    <= commit;
      regWrite_out <= commit & regWrite_in;
      wrReg_out    <= commit ? wrReg_in : '0;
      wbData_out   <= commit ? wb_data : '0;
      halt_out     <= commit & halt_in;
      halt         <= commit & halt_in;
      memRead      <= commit & from_mem & is_load;
      memWrite     <= commit & from_mem & is_store;
      aluResult    <= commit ? aluResult_in : '0;
      writeData    <= (commit & from_mem & is_store) ? writeData_in : '0;
      readData     <= (commit & from_mem & is_load) ? mem_rdata : '0;
      dcache_req   <= commit & from_mem;
      dcache_hit   <= commit & from_mem & mem_hit;
    end
  end
endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage: a commit-queue model predicts every MEM/WB result,
// one negedge process compares it each cycle, and directed steps check stall/strobes.
module tb_dmem_stage;
  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          valid_in, memRead_in, memWrite_in, memToReg_in, regWrite_in, halt_in;
  logic [RW-1:0] wrReg_in;
  logic [DW-1:0] aluResult_in, writeData_in, mem_rdata;
  logic          mem_done, mem_stall, mem_hit, mem_err;
  logic          stall, mem_rd, mem_wr, valid_out, regWrite_out, halt_out;
  logic [DW-1:0] mem_addr, mem_wdata, wbData_out, aluResult, writeData, readData;
  logic [RW-1:0] wrReg_out;
  logic          memRead, memWrite, halt, dcache_req, dcache_hit, err;

  dmem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .memToReg_in(memToReg_in), .regWrite_in(regWrite_in),
    .wrReg_in(wrReg_in), .halt_in(halt_in), .aluResult_in(aluResult_in),
    .writeData_in(writeData_in), .stall(stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit), .mem_err(mem_err),
    .valid_out(valid_out), .regWrite_out(regWrite_out), .wrReg_out(wrReg_out),
    .wbData_out(wbData_out), .halt_out(halt_out), .memRead(memRead),
    .memWrite(memWrite), .halt(halt), .aluResult(aluResult), .writeData(writeData),
    .readData(readData), .dcache_req(dcache_req), .dcache_hit(dcache_hit), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  typedef struct {
    logic          regw;
    logic [RW-1:0] wreg;
    logic [DW-1:0] wb;
    logic          hlt, mr, mw;
    logic [DW-1:0] alu, wd, rd;
    logic          dreq, dhit;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; memRead_in = 0; memWrite_in = 0; memToReg_in = 0; regWrite_in = 0;
    halt_in = 0; wrReg_in = '0; aluResult_in = '0; writeData_in = '0;
    mem_rdata = '0; mem_done = 0; mem_stall = 0; mem_hit = 0; mem_err = 0;
  endtask

  // One commit per cycle at most; anything committing with an empty queue is wrong.
  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      if (valid_out === 1'b1) begin
        if (expq.size() == 0) chk("extra_commit", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("regWrite_out", regWrite_out, e.regw);
          chk("wrReg_out", wrReg_out, e.wreg);
          chk("wbData_out", wbData_out, e.wb);
          chk("halt_out", halt_out, e.hlt);
          chk("halt", halt, e.hlt);
          chk("memRead", memRead, e.mr);
          chk("memWrite", memWrite, e.mw);
          chk("aluResult", aluResult, e.alu);
          chk("writeData", writeData, e.wd);
          chk("readData", readData, e.rd);
          chk("dcache_req", dcache_req, e.dreq);
          chk("dcache_hit", dcache_hit, e.dhit);
        end
      end else begin
        chk("quiet_obs", {31'd0, |{valid_out, regWrite_out, wrReg_out, wbData_out, halt_out,
             memRead, memWrite, halt, aluResult, writeData, readData, dcache_req,
             dcache_hit}}, 32'd0);
      end
    end
  end

  // Present one op and act as the memory: nstall busy cycles, done ndone cycles after accept.
  task automatic op(input logic rd, input logic wr, input logic m2r, input logic rw,
                    input logic [RW-1:0] wreg, input logic hlt, input logic [DW-1:0] alu,
                    input logic [DW-1:0] wd, input int nstall, input int ndone,
                    input logic [DW-1:0] rdata, input logic hit);
    exp_t e;
    logic is_mem;
    is_mem = rd | wr;
    e.regw = rw; e.wreg = wreg; e.hlt = hlt; e.alu = alu;
    e.mw   = wr;
    e.mr   = rd & ~wr;
    e.wb   = (is_mem && m2r) ? rdata : alu;
    e.rd   = e.mr ? rdata : '0;
    e.wd   = e.mw ? wd : '0;
    e.dreq = is_mem;
    e.dhit = is_mem & hit;
    valid_in = 1; memRead_in = rd; memWrite_in = wr; memToReg_in = m2r;
    regWrite_in = rw; wrReg_in = wreg; halt_in = hlt; aluResult_in = alu; writeData_in = wd;
    if (!is_mem) begin
      @(negedge clk);
      chk("alu_stall", stall, 0);
      chk("alu_strobes", {mem_rd, mem_wr}, 0);
      expq.push_back(e);
      step();
    end else begin
      for (int i = 0; i <= nstall; i++) begin
        mem_stall = (i < nstall);
        @(negedge clk);
        chk("req_stall", stall, 1);
        chk("req_strobes", {mem_rd, mem_wr}, {rd & ~wr, wr});
        chk("req_addr", mem_addr, alu);
        chk("req_wdata", mem_wdata, wd);
        step();
      end
      mem_stall = 0;
      for (int j = 1; j <= ndone; j++) begin
        if (j == ndone) begin
          mem_done = 1; mem_rdata = rdata; mem_hit = hit;
        end
        @(negedge clk);
        chk("wait_stall", stall, (j != ndone));
        chk("wait_strobes", {mem_rd, mem_wr}, 0);
        if (j == ndone) expq.push_back(e);
        step();
        mem_done = 0; mem_rdata = '0; mem_hit = 0;
      end
    end
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    step();
    @(negedge clk);
    chk("rst_outs", {31'd0, |{stall, mem_rd, mem_wr, mem_addr, mem_wdata, valid_out,
         regWrite_out, wrReg_out, wbData_out, halt_out, memRead, memWrite, halt,
         aluResult, writeData, readData, dcache_req, dcache_hit}}, 32'd0);
    chk("rst_err", err, 0);
    chk_on = 1;
    expq.delete();
    step();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1;
    step();
    do_reset();

    // ADD r3 = 0x1234
    op(0, 0, 0, 1, 3'd3, 0, 16'h1234, 16'h0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("add_valid", valid_out, 1);
    chk("add_wb", wbData_out, 16'h1234);
    chk("add_wreg", wrReg_out, 3);
    step();

    // load hit from 0x0040, done one cycle after request
    op(1, 0, 1, 1, 3'd5, 0, 16'h0040, 16'h0, 0, 1, 16'hBEEF, 1);
    @(negedge clk);
    chk("ld_wb", wbData_out, 16'hBEEF);
    chk("ld_readData", readData, 16'hBEEF);
    chk("ld_memRead", memRead, 1);
    chk("ld_dreq", dcache_req, 1);
    chk("ld_dhit", dcache_hit, 1);
    step();

    // store miss with two busy cycles; rdata on done must not leak into readData
    op(0, 1, 0, 0, 3'd0, 0, 16'h0080, 16'hCAFE, 2, 4, 16'h1111, 0);
    @(negedge clk);
    chk("st_memWrite", memWrite, 1);
    chk("st_writeData", writeData, 16'hCAFE);
    chk("st_alu", aluResult, 16'h0080);
    chk("st_dhit", dcache_hit, 0);
    chk("st_readData", readData, 0);

    // back-to-back: load with memToReg=0, then ALU op
    op(1, 0, 0, 1, 3'd6, 0, 16'h0022, 16'h0, 1, 3, 16'hA5A5, 0);
    op(0, 0, 0, 0, 3'd1, 0, 16'h0F0F, 16'h0, 0, 0, 16'h0, 0);

    // stray mem_done while idle
    mem_done = 1; mem_rdata = 16'h9999; mem_hit = 1;
    @(negedge clk);
    chk("stray_stall", stall, 0);
    step();
    clear_inputs();
    repeat (2) step();

    // HALT, then valid ops that must be discarded
    op(0, 0, 0, 0, 3'd0, 1, 16'h0007, 16'h0, 0, 0, 16'h0, 0);
    @(negedge clk);
    chk("halt_lit", halt, 1);
    chk("halt_out_lit", halt_out, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      valid_in = 1; regWrite_in = 1; wrReg_in = 3'd2; aluResult_in = 16'h0100 + 16'(k);
      memRead_in = k[0];
      @(negedge clk);
      chk("halted_stall", stall, 0);
      chk("halted_strobes", {mem_rd, mem_wr}, 0);
    end
    step();
    do_reset();

    // reset while waiting, then a stray mem_done
    valid_in = 1; memRead_in = 1; memToReg_in = 1; regWrite_in = 1; wrReg_in = 3'd4;
    aluResult_in = 16'h0100;
    @(negedge clk);
    chk("rw_req", mem_rd, 1);
    step();
    @(negedge clk);
    chk("rw_wait_stall", stall, 1);
    rst = 1;
    clear_inputs();
    step();
    rst = 0;
    mem_done = 1; mem_rdata = 16'hDEAD; mem_hit = 1;
    @(negedge clk);
    chk("rw_stray_stall", stall, 0);
    chk("rw_outs", {31'd0, |{valid_out, wbData_out, readData, memRead, dcache_req}}, 32'd0);
    step();
    clear_inputs();
    @(negedge clk);
    chk("rw_no_commit", valid_out, 0);
    step();
    op(1, 0, 1, 1, 3'd2, 0, 16'h0200, 16'h0, 1, 2, 16'h4242, 1);
    @(negedge clk);
    chk("rw_next_ld", wbData_out, 16'h4242);
    chk("err_clean", err, 0);
    step();

    // read+write conflict executes as a store and raises err
    op(1, 1, 0, 0, 3'd0, 0, 16'h0010, 16'h5555, 0, 2, 16'h7777, 1);
    @(negedge clk);
    chk("cf_err", err, 1);
    chk("cf_memWrite", memWrite, 1);
    chk("cf_memRead", memRead, 0);
    repeat (3) step();
    @(negedge clk);
    chk("cf_err_sticky", err, 1);
    step();
    do_reset();

    mem_err = 1;
    step();
    mem_err = 0;
    @(negedge clk);
    chk("merr_err", err, 1);
    repeat (3) step();
    @(negedge clk);
    chk("merr_sticky", err, 1);
    step();
    do_reset();

    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
